// File: rtl/frame_acc32.sv
// Groups every 32 accepted 8-bit samples into a frame and reports the frame's
// sum, average, maximum and minimum with a one-cycle strobe.
module frame_acc32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_valid,
   input  logic [7:0]  din,
   output logic [4:0]  idx,
   output logic        busy,
   output logic        out_valid,
   output logic [12:0] sum,
   output logic [7:0]  avg,
   output logic [7:0]  max,
   output logic [7:0]  min
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t      state;
   logic [12:0] acc;
   logic [7:0]  run_max;
   logic [7:0]  run_min;

   logic        first;
   logic [12:0] acc_next;
   logic [7:0]  max_next;
   logic [7:0]  min_next;

   // A frame's first sample always arrives with idx=0, whether from IDLE or DONE.
   always_comb begin
      first    = (idx == 5'd0);
      acc_next = first ? {5'd0, din} : acc + {5'd0, din};
      max_next = (first || (din > run_max)) ? din : run_max;
      min_next = (first || (din < run_min)) ? din : run_min;
   end

   // NOTE: non-blocking assignments keep every register reading pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= 5'd0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         sum       <= 13'd0;
         max       <= 8'd0;
         min       <= 8'd0;
         // NOTE: working registers are reset too, so a fresh run never sees stale data.
         acc       <= 13'd0;
         run_max   <= 8'd0;
         run_min   <= 8'd0;
      end else begin
         out_valid <= 1'b0;
         if (data_valid) begin
            acc     <= acc_next;
            run_max <= max_next;
            run_min <= min_next;
            if (idx == 5'd31) begin
               sum       <= acc_next;
               max       <= max_next;
               min       <= min_next;
               out_valid <= 1'b1;
               idx       <= 5'd0;
               busy      <= 1'b0;
               state     <= DONE;
            end else begin
               idx   <= idx + 5'd1;
               busy  <= 1'b1;
               state <= ACC;
            end
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end

   assign avg = sum[12:5];

endmodule

// File: tb/tb_frame_acc32.sv
// Directed bench for frame_acc32: a behavioural frame model pushes expected
// results into a scoreboard that is popped whenever out_valid strobes.
module tb_frame_acc32;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_valid;
   logic [7:0]  din;
   logic [4:0]  idx;
   logic        busy;
   logic        out_valid;
   logic [12:0] sum;
   logic [7:0]  avg;
   logic [7:0]  max;
   logic [7:0]  min;

   frame_acc32 dut (
      .clk        (clk),
      .rst        (rst),
      .data_valid (data_valid),
      .din        (din),
      .idx        (idx),
      .busy       (busy),
      .out_valid  (out_valid),
      .sum        (sum),
      .avg        (avg),
      .max        (max),
      .min        (min)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] sum;
      logic [7:0]  mx;
      logic [7:0]  mn;
      int          edge_no;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          errors   = 0;
   int          edge_cnt = 0;
   int          m_cnt    = 0;
   logic [12:0] m_sum    = '0;
   logic [7:0]  m_max    = '0;
   logic [7:0]  m_min    = '0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // One clock of stimulus, then update the frame model and check idx/busy.
   task automatic step(input logic dv, input logic [7:0] d);
      data_valid = dv;
      din        = d;
      @(posedge clk);
      #1;
      if (dv) begin
         if (m_cnt == 0) begin
            m_sum = {5'd0, d};
            m_max = d;
            m_min = d;
         end else begin
            m_sum = m_sum + {5'd0, d};
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
         end
         m_cnt++;
         if (m_cnt == 32) begin
            sb.push_back('{m_sum, m_max, m_min, edge_cnt});
            m_cnt = 0;
         end
      end
      check("idx", idx, m_cnt);
      check("busy", busy, m_cnt != 0);
   endtask

   task automatic check_results(input string tag, input int s, input int mx, input int mn);
      check({tag, "_sum"}, sum, s);
      check({tag, "_avg"}, avg, s / 32);
      check({tag, "_max"}, max, mx);
      check({tag, "_min"}, min, mn);
   endtask

   // Every strobe must match the oldest expected frame, on the expected cycle.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         check("pulse_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_cycle", edge_cnt, e.edge_no);
            check("sb_sum", sum, e.sum);
            check("sb_avg", avg, e.sum[12:5]);
            check("sb_max", max, e.mx);
            check("sb_min", min, e.mn);
         end
      end
   end

   initial begin
      rst        = 1'b0;
      data_valid = 1'b0;
      din        = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_idx", idx, 0);
      check("rst_busy", busy, 0);
      check_results("rst", 0, 0, 0);

      // Constant frame of 5.
      for (int i = 0; i < 32; i++) step(1'b1, 8'd5);
      check("const_strobe", out_valid, 1);
      step(1'b0, 8'd0);
      check("const_strobe_len", out_valid, 0);
      check_results("const", 160, 5, 5);

      // Ramp with a gap after every third sample; din is junk during gaps.
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 8'(i));
         if (i % 3 == 2) step(1'b0, 8'($urandom_range(0, 255)));
      end
      step(1'b0, 8'd0);
      check_results("ramp", 496, 31, 0);

      // Full-scale frame.
      for (int i = 0; i < 32; i++) step(1'b1, 8'd255);
      step(1'b0, 8'd0);
      check_results("full", 8160, 255, 255);

      // Back-to-back frames; sample 33 lands in the DONE cycle.
      for (int i = 0; i < 64; i++) begin
         step(1'b1, (i < 32) ? 8'd10 : 8'd20);
         if (i == 31) check_results("b2b_a", 320, 10, 10);
         if (i == 32) check("b2b_idx_wrap", idx, 1);
      end
      step(1'b0, 8'd0);
      check_results("b2b_b", 640, 20, 20);

      // Reset mid-frame, with data_valid high during reset.
      for (int i = 0; i < 10; i++) step(1'b1, 8'd200);
      rst        = 1'b0;
      data_valid = 1'b1;
      din        = 8'd200;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      m_cnt = 0;
      check("mid_rst_idx", idx, 0);
      check_results("mid_rst", 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 8'd1);
         if (i == 15) check_results("mid_rst_hold", 0, 0, 0);
      end
      step(1'b0, 8'd0);
      check_results("after_rst", 32, 1, 1);

      // Incomplete frame after a fresh reset.
      rst        = 1'b0;
      data_valid = 1'b0;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      m_cnt = 0;
      for (int i = 0; i < 31; i++) step(1'b1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom_range(0, 255)));
      check("partial_idx", idx, 31);
      check("partial_busy", busy, 1);
      check_results("partial", 0, 0, 0);

      check("missing_pulse", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_acc32.md
# frame_acc32

Downstream consumer of the 6-bit valid-sample counter in the EF datapath. Receives the same `data_valid`/data stream, groups every 32 accepted samples into a frame, and produces per-frame sum, average, maximum and minimum with a one-cycle result strobe. Results are held stable between strobes. The next frame starts without a gap, so a sample in the strobe cycle is counted.

## Interface
Parameters: none (frame length 32 and data width 8 are fixed).

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; `rst`=0 resets)
- `data_valid`  in  1  `din` carries a sample this cycle
- `din`  in  8  unsigned sample
- `idx`  out  5  number of samples accepted in the current partial frame (0..31)
- `busy`  out  1  1 while a partial frame is open (`idx`≠0)
- `out_valid`  out  1  one-cycle strobe: results below updated this cycle
- `sum`  out  13  sum of the last completed frame's 32 samples
- `avg`  out  8  `sum[12:5]` (truncating divide by 32)
- `max`  out  8  largest sample of the last completed frame
- `min`  out  8  smallest sample of the last completed frame

## Operation
- States:
  - IDLE: no partial frame, `idx`=0.
  - ACC: partial frame open, `idx` 1..31.
  - DONE: single cycle with `out_valid`=1.
- Transitions:
  - IDLE: `data_valid`=1 → ACC; otherwise stay.
  - ACC: `data_valid`=1 with `idx`=31 → DONE; `data_valid`=1 with `idx`<31 → `idx`+1, stay; `data_valid`=0 → hold everything.
  - DONE: `data_valid`=1 → ACC with that sample as sample 0 of the new frame; otherwise → IDLE.
- Running registers:
  - Working accumulator, 13 bits, cannot overflow: 32×255=8160 < 8192.
  - Running max and running min.
  - On the first sample of a frame, load accumulator=`din`, max=`din`, min=`din`. On later samples, accumulate and compare (max/min compares are unsigned).
- On the 32nd sample:
  - `sum`/`max`/`min`/`avg` output registers load the final values, including that sample.
  - `out_valid` is set for the next cycle.
- Output registers change only on entry to DONE; they hold across IDLE/ACC.
- `data_valid`=0 cycles inside a frame are ignored; `din` is don't-care then.

## Timing
- Reset values: `idx`=0, `busy`=0, `out_valid`=0, `sum`=0, `avg`=0, `max`=0, `min`=0, state IDLE, working registers 0.
- Latency: `out_valid` and the new results appear 1 cycle after the edge that accepts the 32nd sample.
- `out_valid` is high for exactly 1 cycle per frame, never 2 consecutive cycles: a new frame needs ≥32 more samples.
- `idx` and `busy` are registered and reflect samples accepted up to the previous edge. `idx` wraps 31→0 on frame completion, or to 1 if a sample arrives in DONE.
- Reset mid-frame: partial frame discarded, no strobe, outputs cleared to 0. Reset overrides `data_valid` in the same cycle.
- Reset asserted during DONE: `out_valid` drops at that edge; results cleared.
- Maximum throughput: 1 sample/cycle indefinitely, frames back-to-back.

## Test plan
- Reset, then 32 consecutive samples of 5 → one `out_valid` pulse on the cycle after sample 32; `sum`=160, `avg`=5, `max`=5, `min`=5; `idx` returns to 0, `busy`=0.
- Ramp 0..31 with a `data_valid`=0 gap after every third sample → `sum`=496, `avg`=15, `max`=31, `min`=0. Check `idx` holds during gaps.
- 32 samples of 255 → `sum`=8160, `avg`=255 (no overflow).
- Back-to-back frames: 64 samples, 1 per cycle, values 10 for frame A and 20 for frame B (sample 33 lands in the DONE cycle).
  - Frame A: pulse with `sum`=320, `min`=`max`=10.
  - Frame B: pulse exactly 32 cycles later with `sum`=640, `min`=`max`=20.
  - No extra or missing pulse.
- Reset mid-frame: 10 samples of 200, `rst`=0 for 1 cycle, then 32 samples of 1 → single pulse with `sum`=32, `max`=1, `min`=1. Outputs read 0 between the reset and that pulse.
- Incomplete frame: 31 samples then 20 idle cycles → no `out_valid`, `idx`=31, `busy`=1, outputs remain at reset values.
